cond_unit: RTL and testbench

Conditional-execution and flag-storage block for the single-cycle CPU. It sits between the main/ALU decoders and the datapath. It holds the architectural NZCV flags and evaluates the instruction's 4-bit condition field against them. It then gates the decoders' write-enables so that an instruction whose condition fails has no architectural effect. It consumes the 2-bit flag-write request produced by the ALU decoder and owns the state that request refers to.

---
 rtl/cond_unit.sv | 82 ++++++++
 tb/tb_cond_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the NZCV flags, evaluates the condition
// field against them and gates the decoder write-enables.
module cond_unit (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic [1:0] i_flag_w,
    input  logic       i_no_write,
    input  logic       i_pcs,
    input  logic       i_reg_w,
    input  logic       i_mem_w,
    output logic [3:0] o_flags,
    output logic       o_cond_ex,
    output logic       o_pc_src,
    output logic       o_reg_write,
    output logic       o_mem_write
);

    logic r_n;
    logic r_z;
    logic r_c;
    logic r_v;
    logic w_cond_raw;
    logic w_cond_ex;

    function automatic logic cond_eval(input logic [3:0] cond, input logic n,
                                       input logic z, input logic c, input logic v);
        logic pass;
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = ~z & (n == v);
            4'b1101: pass = z | (n != v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    // Evaluated only against stored flags so an instruction never sees its own result.
    always_comb begin
        w_cond_raw = cond_eval(i_cond, r_n, r_z, r_c, r_v);
    end

    assign w_cond_ex   = i_rst_n & w_cond_raw;
    assign o_cond_ex   = w_cond_ex;
    assign o_pc_src    = i_pcs & w_cond_ex;
    assign o_reg_write = i_reg_w & w_cond_ex & ~i_no_write;
    assign o_mem_write = i_mem_w & w_cond_ex;
    assign o_flags     = {r_n, r_z, r_c, r_v};

    // N,Z and C,V halves update independently so logical ops preserve C,V.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_c <= 1'b0;
            r_v <= 1'b0;
        end else begin
            if (i_flag_w[1] && w_cond_ex) begin
                r_n <= i_alu_flags[3];
                r_z <= i_alu_flags[2];
            end
            if (i_flag_w[0] && w_cond_ex) begin
                r_c <= i_alu_flags[1];
                r_v <= i_alu_flags[0];
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit.
module tb_cond_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       no_write;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic [3:0] flags;
    logic       cond_ex;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;

    int checks   = 0;
    int failures = 0;

    cond_unit dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cond      (cond),
        .i_alu_flags (alu_flags),
        .i_flag_w    (flag_w),
        .i_no_write  (no_write),
        .i_pcs       (pcs),
        .i_reg_w     (reg_w),
        .i_mem_w     (mem_w),
        .o_flags     (flags),
        .o_cond_ex   (cond_ex),
        .o_pc_src    (pc_src),
        .o_reg_write (reg_write),
        .o_mem_write (mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] v);
        cond      = 4'b1110;
        flag_w    = 2'b11;
        alu_flags = v;
        pcs       = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        no_write  = 1'b0;
        tick();
        flag_w    = 2'b00;
    endtask

    // Reference condition table written out from the ISA definition.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; cond = 4'b1110; alu_flags = 4'b1111; flag_w = 2'b11;
        no_write = 1'b0; pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
        #1;
        check("reset_flags", flags, 4'b0000);
        check("reset_cond_ex", {3'b0, cond_ex}, 4'b0000);
        check("reset_gated", {1'b0, pc_src, reg_write, mem_write}, 4'b0000);
        tick();
        check("reset_edge_hold", flags, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        flag_w = 2'b00;
        #1;
        check("release_gated", {cond_ex, pc_src, reg_write, mem_write}, 4'b1111);

        // CMP equal
        cond = 4'b1110; alu_flags = 4'b0100; flag_w = 2'b11; no_write = 1'b1;
        reg_w = 1'b1; pcs = 1'b0; mem_w = 1'b0;
        #1;
        check("cmp_regwrite", {3'b0, reg_write}, 4'b0000);
        tick();
        check("cmp_flags", flags, 4'b0100);
        flag_w = 2'b00; no_write = 1'b0; cond = 4'b0000; reg_w = 1'b1;
        #1;
        check("eq_regwrite", {3'b0, reg_write}, 4'b0001);
        cond = 4'b0001;
        #1;
        check("ne_regwrite", {3'b0, reg_write}, 4'b0000);

        // Partial update keeps C,V
        set_flags(4'b0011);
        check("pre_ands_flags", flags, 4'b0011);
        cond = 4'b1110; alu_flags = 4'b1000; flag_w = 2'b10;
        tick();
        check("ands_flags", flags, 4'b1011);
        alu_flags = 4'b0101; flag_w = 2'b01;
        tick();
        check("cv_only_flags", flags, 4'b1001);
        alu_flags = 4'b0110; flag_w = 2'b00;
        tick();
        check("hold_flags", flags, 4'b1001);

        // Failed condition blocks flags and writes
        set_flags(4'b0000);
        cond = 4'b0000; flag_w = 2'b11; alu_flags = 4'b1111; pcs = 1'b1; mem_w = 1'b1;
        #1;
        check("fail_gated", {2'b0, pc_src, mem_write}, 4'b0000);
        tick();
        check("fail_flags", flags, 4'b0000);
        pcs = 1'b0; mem_w = 1'b0;

        // Conditional flag-setter sees old flags
        set_flags(4'b0100);
        cond = 4'b0000; flag_w = 2'b11; alu_flags = 4'b0000;
        #1;
        check("addeqs_pass", {3'b0, cond_ex}, 4'b0001);
        tick();
        check("addeqs_flags", flags, 4'b0000);
        check("addeqs_after", {3'b0, cond_ex}, 4'b0000);

        // Sweep all flags x all conditions
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            check("sweep_flags", flags, 4'(f));
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                #1;
                check($sformatf("sweep_f%0d_c%0d", f, c), {3'b0, cond_ex},
                      {3'b0, ref_cond(4'(c), 4'(f))});
            end
        end

        set_flags(4'b1000);
        cond = 4'b1011;
        #1;
        check("spot_lt", {3'b0, cond_ex}, 4'b0001);
        cond = 4'b1100;
        #1;
        check("spot_gt", {3'b0, cond_ex}, 4'b0000);
        cond = 4'b1010;
        #1;
        check("spot_ge", {3'b0, cond_ex}, 4'b0000);

        // Back-to-back dependency
        set_flags(4'b0010);
        cond = 4'b1000; pcs = 1'b1;
        #1;
        check("b2b_hi_taken", {3'b0, pc_src}, 4'b0001);
        set_flags(4'b0110);
        cond = 4'b1000; pcs = 1'b1;
        #1;
        check("b2b_hi_not", {3'b0, pc_src}, 4'b0000);

        // Mid-cycle asynchronous reset
        set_flags(4'b1111);
        check("pre_rst_flags", flags, 4'b1111);
        cond = 4'b1110; pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1; no_write = 1'b0;
        flag_w = 2'b11; alu_flags = 4'b0101;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_flags", flags, 4'b0000);
        check("async_rst_gated", {cond_ex, pc_src, reg_write, mem_write}, 4'b0000);
        tick();
        check("rst_hold_flags", flags, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        alu_flags = 4'b1010;
        #1;
        check("rst_release_gated", {cond_ex, pc_src, reg_write, mem_write}, 4'b1111);
        tick();
        check("first_edge_update", flags, 4'b1010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
